// File: rtl/traffic_pkg.sv
// Shared state encodings and lamp patterns for the intersection controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    HG    = 3'd0,
    HY    = 3'd1,
    AR1   = 3'd2,
    FG    = 3'd3,
    FY    = 3'd4,
    AR2   = 3'd5,
    FLASH = 3'd6
  } state_t;

  // Lamp groups are {red, yellow, green}.
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_DIV clocks; clr restarts the count.
module tick_gen #(
  parameter int CLK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  assign tick = (count_q == LAST);

  always_comb begin
    if (clr || tick) count_d = '0;
    else             count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/traffic_light_ctrl_param.sv
// Highway/farm-road controller: timed phases, all-red clearance, latched farm
// requests, farm green extension by sensor, and a night flashing mode.
module traffic_light_ctrl_param
  import traffic_pkg::*;
#(
  parameter int CLK_DIV        = 50000000,
  parameter int TW             = 8,
  parameter int HWY_MIN_GREEN  = 10,
  parameter int FARM_MIN_GREEN = 5,
  parameter int FARM_MAX_GREEN = 10,
  parameter int YELLOW_T       = 3,
  parameter int ALL_RED_T      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor,
  input  logic       flash_mode,
  output logic [2:0] light_highway,
  output logic [2:0] light_farm,
  output logic [2:0] state_o
);

  localparam logic [TW-1:0] HWY_MIN_C  = TW'(HWY_MIN_GREEN);
  localparam logic [TW-1:0] FARM_MIN_C = TW'(FARM_MIN_GREEN);
  localparam logic [TW-1:0] FARM_MAX_C = TW'(FARM_MAX_GREEN);
  localparam logic [TW-1:0] YEL_C      = TW'(YELLOW_T);
  localparam logic [TW-1:0] AR_C       = TW'(ALL_RED_T);

  state_t        state_q, state_d;
  logic          req_q, req_d;
  logic          blink_q, blink_d;
  logic [TW-1:0] elapsed_q, elapsed_d, elapsed_n;
  logic          tick;
  logic          state_chg;
  logic          fg_entry;

  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_chg),
    .tick (tick)
  );

  // elapsed_n is the value elapsed takes after this edge, so a phase ends on
  // the very tick that brings it to its duration.
  assign elapsed_n = (tick && (elapsed_q != '1)) ? elapsed_q + 1'b1 : elapsed_q;
  assign state_chg = (state_d != state_q);
  assign fg_entry  = (state_d == FG) && (state_q != FG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= HG;
      req_q     <= 1'b0;
      blink_q   <= 1'b1;
      elapsed_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      blink_q   <= blink_d;
      elapsed_q <= elapsed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HG:    if (flash_mode || (req_q && elapsed_n >= HWY_MIN_C)) state_d = HY;
      HY:    if (tick && elapsed_n >= YEL_C) state_d = AR1;
      AR1:   if (tick && elapsed_n >= AR_C) state_d = flash_mode ? FLASH : FG;
      FG:    if (flash_mode ||
                 (elapsed_n >= FARM_MIN_C && (!sensor || elapsed_n >= FARM_MAX_C)))
               state_d = FY;
      FY:    if (tick && elapsed_n >= YEL_C) state_d = AR2;
      AR2:   if (tick && elapsed_n >= AR_C) state_d = flash_mode ? FLASH : HG;
      FLASH: if (!flash_mode) state_d = AR2;
      default: state_d = HG;
    endcase
  end

  always_comb begin
    elapsed_d = state_chg ? '0 : elapsed_n;

    // Clearing on FG entry wins over a simultaneous sensor sample.
    req_d = req_q;
    if (fg_entry)                         req_d = 1'b0;
    else if (sensor && (state_q != FG))   req_d = 1'b1;

    blink_d = blink_q;
    if ((state_d == FLASH) && (state_q != FLASH)) blink_d = 1'b1;
    else if ((state_q == FLASH) && tick)          blink_d = ~blink_q;
  end

  always_comb begin
    light_highway = RED;
    light_farm    = RED;
    case (state_q)
      HG:    begin light_highway = GRN; light_farm = RED; end
      HY:    begin light_highway = YEL; light_farm = RED; end
      AR1:   begin light_highway = RED; light_farm = RED; end
      FG:    begin light_highway = RED; light_farm = GRN; end
      FY:    begin light_highway = RED; light_farm = YEL; end
      AR2:   begin light_highway = RED; light_farm = RED; end
      FLASH: begin
        light_highway = blink_q ? YEL : OFF;
        light_farm    = blink_q ? RED : OFF;
      end
      default: begin light_highway = RED; light_farm = RED; end
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// Directed bench for traffic_light_ctrl_param with CLK_DIV=4; cycle k is the
// interval after the k-th rising edge following reset release.
module tb_traffic_light_ctrl_param;

  localparam logic [2:0] S_HG = 3'd0, S_HY = 3'd1, S_AR1 = 3'd2, S_FG = 3'd3,
                         S_FY = 3'd4, S_AR2 = 3'd5, S_FL = 3'd6;
  localparam logic [2:0] L_R = 3'b100, L_Y = 3'b010, L_G = 3'b001, L_O = 3'b000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sensor = 1'b0;
  logic       flash_mode = 1'b0;
  logic [2:0] light_highway, light_farm, state_o;

  int n_assert = 0;
  int n_fail   = 0;

  traffic_light_ctrl_param #(.CLK_DIV(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .sensor        (sensor),
    .flash_mode    (flash_mode),
    .light_highway (light_highway),
    .light_farm    (light_farm),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] st, input logic [2:0] hw,
                     input logic [2:0] fm);
    n_assert++;
    assert ({state_o, light_highway, light_farm} === {st, hw, fm}) else begin
      n_fail++;
      $error("FAIL %s t=%0t state/hwy/farm got %0d/%b/%b expected %0d/%b/%b",
             tag, $time, state_o, light_highway, light_farm, st, hw, fm);
    end
  endtask

  // Checks one state/lamp pattern on each of n consecutive cycles.
  task automatic hold(input string tag, input logic [2:0] st, input logic [2:0] hw,
                      input logic [2:0] fm, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, st, hw, fm);
      cyc(1);
    end
    $display("segment %s: state %0d for %0d cycles checked", tag, st, n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    chk("reset_vals", S_HG, L_G, L_R);
    rst = 1'b0;
  endtask

  initial begin
    // 1: idle HG, no sensor
    sensor = 1'b0; flash_mode = 1'b0;
    do_reset();
    hold("t1_idle_hg", S_HG, L_G, L_R, 500);

    // 2: single-cycle sensor pulse at cycle 5
    do_reset();
    cyc(5);
    sensor = 1'b1;
    cyc(1);
    sensor = 1'b0;
    hold("t2_hg",  S_HG,  L_G, L_R, 34);
    hold("t2_hy",  S_HY,  L_Y, L_R, 12);
    hold("t2_ar1", S_AR1, L_R, L_R, 4);
    hold("t2_fg",  S_FG,  L_R, L_G, 20);
    hold("t2_fy",  S_FY,  L_R, L_Y, 12);
    hold("t2_ar2", S_AR2, L_R, L_R, 4);
    hold("t2_hg_no_req", S_HG, L_G, L_R, 60);

    // 3: sensor held high from cycle 0, farm green runs to max
    do_reset();
    sensor = 1'b1;
    hold("t3_hg",  S_HG,  L_G, L_R, 40);
    hold("t3_hy",  S_HY,  L_Y, L_R, 12);
    hold("t3_ar1", S_AR1, L_R, L_R, 4);
    hold("t3_fg_max", S_FG, L_R, L_G, 40);
    hold("t3_fy",  S_FY,  L_R, L_Y, 12);
    hold("t3_ar2", S_AR2, L_R, L_R, 4);
    hold("t3_hg2", S_HG,  L_G, L_R, 40);
    chk("t3_hy2", S_HY, L_Y, L_R);
    sensor = 1'b0;

    // 4: request after minimum green already elapsed
    do_reset();
    hold("t4_hg", S_HG, L_G, L_R, 100);
    sensor = 1'b1;
    chk("t4_c100", S_HG, L_G, L_R);
    cyc(1);
    sensor = 1'b0;
    chk("t4_c101", S_HG, L_G, L_R);
    cyc(1);
    chk("t4_c102_hy", S_HY, L_Y, L_R);

    // 5: flash mode entered from farm green, then released
    do_reset();
    sensor = 1'b1;
    hold("t5_hg",  S_HG,  L_G, L_R, 40);
    hold("t5_hy",  S_HY,  L_Y, L_R, 12);
    hold("t5_ar1", S_AR1, L_R, L_R, 4);
    hold("t5_fg",  S_FG,  L_R, L_G, 8);
    flash_mode = 1'b1;
    sensor = 1'b0;
    hold("t5_fg_last", S_FG, L_R, L_G, 1);
    hold("t5_fy",  S_FY,  L_R, L_Y, 12);
    hold("t5_ar2", S_AR2, L_R, L_R, 4);
    hold("t5_fl_on1",  S_FL, L_Y, L_R, 4);
    hold("t5_fl_off1", S_FL, L_O, L_O, 4);
    hold("t5_fl_on2",  S_FL, L_Y, L_R, 4);
    flash_mode = 1'b0;
    hold("t5_fl_exit", S_FL, L_O, L_O, 1);
    hold("t5_ar2b", S_AR2, L_R, L_R, 4);
    hold("t5_hg_back", S_HG, L_G, L_R, 10);

    // 6: async reset 5 cycles into FY discards a pending request
    do_reset();
    sensor = 1'b1;
    cyc(1);
    sensor = 1'b0;
    hold("t6_hg",  S_HG,  L_G, L_R, 39);
    hold("t6_hy",  S_HY,  L_Y, L_R, 12);
    hold("t6_ar1", S_AR1, L_R, L_R, 4);
    hold("t6_fg",  S_FG,  L_R, L_G, 20);
    hold("t6_fy_a", S_FY, L_R, L_Y, 2);
    sensor = 1'b1;
    hold("t6_fy_b", S_FY, L_R, L_Y, 3);
    chk("t6_fy_c81", S_FY, L_R, L_Y);
    #3 rst = 1'b1;
    #1 chk("t6_async_rst", S_HG, L_G, L_R);
    sensor = 1'b0;
    cyc(2);
    rst = 1'b0;
    hold("t6_hg_req_gone", S_HG, L_G, L_R, 60);
    sensor = 1'b1;
    chk("t6_c60", S_HG, L_G, L_R);
    cyc(1);
    sensor = 1'b0;
    chk("t6_c61", S_HG, L_G, L_R);
    cyc(1);
    chk("t6_c62_hy", S_HY, L_Y, L_R);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
